phantom_dummy_axil_regs: RTL and testbench

AXI4-Lite slave (responder) exposing a 4-word read/write register bank to a PS/BFM AXI4-Lite master, with byte-lane write strobes and an 8-word decode window. It is the register end of the simple write-then-read example traffic the PHANTOM dummy IP bench issues to `S00_AXI_SLAVE_ADDRESS`: 4 consecutive words at +0x0, +0x4, +0x8 and +0xC. Registers drive a `reg_out` bus to the user logic.

---
 rtl/phantom_dummy_axil_regs.sv | 170 +++++++++++++++++
 tb/tb_phantom_dummy_axil_regs.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phantom_dummy_axil_regs.sv
// AXI4-Lite register slave: 4 RW words in an 8-word window, byte strobes, reg_out mirror.
// Build option: define PHANTOM_DUMMY_SLVERR_EN to answer words 4-7 with SLVERR instead of OKAY.
module phantom_dummy_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_out
);
   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = DW / 8;
   localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef PHANTOM_DUMMY_SLVERR_EN
   localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
   localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

   typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

   logic            rst_done_q;
   logic            aw_held_q, aw_held_d;
   logic            w_held_q, w_held_d;
   logic            bvalid_q, bvalid_d;
   logic [1:0]      bresp_q, bresp_d;
   logic [2:0]      awaddr_q, awaddr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [SW-1:0]   wstrb_q, wstrb_d;
   logic [DW-1:0]   regs_q [4];
   logic [DW-1:0]   regs_d [4];
   rd_state_e       rd_state_q, rd_state_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic [1:0]      rresp_q, rresp_d;

   logic            aw_hs, w_hs, ar_hs, commit;
   logic [2:0]      wr_word;
   logic [DW-1:0]   wr_data;
   logic [SW-1:0]   wr_strb;
   logic            unused_inputs;

   assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // READYs depend on registered state only, never on the VALIDs.
   assign S_AXI_AWREADY = rst_done_q & ~aw_held_q & ~bvalid_q;
   assign S_AXI_WREADY  = rst_done_q & ~w_held_q & ~bvalid_q;
   assign S_AXI_ARREADY = rst_done_q & (rd_state_q == RD_IDLE);

   assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
   assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
   assign commit = (aw_held_q | aw_hs) & (w_held_q | w_hs);

   assign wr_word = aw_held_q ? awaddr_q : S_AXI_AWADDR[4:2];
   assign wr_data = w_held_q ? wdata_q : S_AXI_WDATA;
   assign wr_strb = w_held_q ? wstrb_q : S_AXI_WSTRB;

   always_comb begin
      // NOTE: every signal gets its default first so no path through this block infers a latch.
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      regs_d    = regs_q;
      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = wr_word[2] ? RESP_UNMAPPED : RESP_OKAY;
         if (!wr_word[2]) begin
            for (int b = 0; b < SW; b++) begin
               if (wr_strb[b]) regs_d[wr_word[1:0]][8*b +: 8] = wr_data[8*b +: 8];
            end
         end
      end else begin
         if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = S_AXI_AWADDR[4:2];
         end
         if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
         end
         if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
      end
   end

   // Reads sample regs_q, so a same-edge write to the same word returns the old value.
   always_comb begin
      rd_state_d = rd_state_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      case (rd_state_q)
         RD_IDLE: begin
            if (ar_hs) begin
               rd_state_d = RD_RESP;
               rdata_d    = S_AXI_ARADDR[4] ? '0 : regs_q[S_AXI_ARADDR[3:2]];
               rresp_d    = S_AXI_ARADDR[4] ? RESP_UNMAPPED : RESP_OKAY;
            end
         end
         RD_RESP: begin
            if (S_AXI_RREADY) rd_state_d = RD_IDLE;
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         rst_done_q <= 1'b0;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         // NOTE: the register bank is reset too, because software must read zeros after reset.
         regs_q     <= '{default: '0};
         rd_state_q <= RD_IDLE;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         rst_done_q <= 1'b1;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         regs_q     <= regs_d;
         rd_state_q <= rd_state_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

   assign S_AXI_BVALID = bvalid_q;
   assign S_AXI_BRESP  = bresp_q;
   assign S_AXI_RVALID = (rd_state_q == RD_RESP);
   assign S_AXI_RDATA  = rdata_q;
   assign S_AXI_RRESP  = rresp_q;
   assign reg_out      = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};

endmodule

// File: tb/tb_phantom_dummy_axil_regs.sv
// Self-checking bench for phantom_dummy_axil_regs: vector table, B/R scoreboards, corner sequences.
module tb_phantom_dummy_axil_regs;
   localparam logic [1:0] OKAY = 2'b00;
`ifdef PHANTOM_DUMMY_SLVERR_EN
   localparam logic [1:0] UNMAP = 2'b10;
`else
   localparam logic [1:0] UNMAP = 2'b00;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [4:0]   awaddr = '0, araddr = '0;
   logic [2:0]   awprot = '0, arprot = '0;
   logic         awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
   logic         bready = 1'b1, rready = 1'b1;
   logic [31:0]  wdata = '0;
   logic [3:0]   wstrb = '0;
   logic         awready, wready, bvalid, arready, rvalid;
   logic [1:0]   bresp, rresp;
   logic [31:0]  rdata;
   logic [127:0] reg_out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] data;
   } rsp_t;
   rsp_t       r_q[$];
   logic [1:0] b_q[$];

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
   } vec_t;
   vec_t vecs[8];

   phantom_dummy_axil_regs dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .reg_out(reg_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboards: pop and compare whenever a response handshake is about to complete.
   always @(negedge clk) begin
      if (bvalid && bready) begin
         if (b_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected: got bresp %0h with no expected write", bresp);
         end else begin
            check("bresp", 128'(bresp), 128'(b_q.pop_front()));
         end
      end
      if (rvalid && rready) begin
         if (r_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL r_unexpected: got rdata %0h with no expected read", rdata);
         end else begin
            rsp_t e;
            e = r_q.pop_front();
            check("rdata", 128'(rdata), 128'(e.data));
            check("rresp", 128'(rresp), 128'(e.resp));
         end
      end
   end

   task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] exp_resp);
      bit aw_f, w_f, b_f;
      bit b_done = 1'b0;
      b_q.push_back(exp_resp);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      for (int c = 0; c < 30 && !b_done; c++) begin
         @(negedge clk);
         aw_f = awvalid && awready;
         w_f  = wvalid && wready;
         b_f  = bvalid && bready;
         @(posedge clk); #1;
         if (aw_f) awvalid = 1'b0;
         if (w_f)  wvalid = 1'b0;
         if (b_f)  b_done = 1'b1;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      check("write_done", 128'(b_done), 128'(1));
   endtask

   task automatic do_read(input logic [4:0] a, input logic [31:0] exp_data, input logic [1:0] exp_resp);
      bit ar_f, r_f;
      bit r_done = 1'b0;
      r_q.push_back('{resp: exp_resp, data: exp_data});
      araddr = a; arvalid = 1'b1;
      for (int c = 0; c < 30 && !r_done; c++) begin
         @(negedge clk);
         ar_f = arvalid && arready;
         r_f  = rvalid && rready;
         @(posedge clk); #1;
         if (ar_f) arvalid = 1'b0;
         if (r_f)  r_done = 1'b1;
      end
      arvalid = 1'b0;
      check("read_done", 128'(r_done), 128'(1));
   endtask

   initial begin
      vecs[0] = '{5'h00, 32'h0101FFFF, 4'hF,    32'h0101FFFF, OKAY};
      vecs[1] = '{5'h04, 32'hABCD0001, 4'hF,    32'hABCD0001, OKAY};
      vecs[2] = '{5'h08, 32'hDEAD0011, 4'hF,    32'hDEAD0011, OKAY};
      vecs[3] = '{5'h0C, 32'hBEEF0011, 4'hF,    32'hBEEF0011, OKAY};
      vecs[4] = '{5'h04, 32'h11223344, 4'b0101, 32'hAB220044, OKAY};
      vecs[5] = '{5'h14, 32'hFFFFFFFF, 4'hF,    32'h00000000, UNMAP};
      vecs[6] = '{5'h1C, 32'h12345678, 4'b0011, 32'h00000000, UNMAP};
      vecs[7] = '{5'h00, 32'hCAFEBABE, 4'b1000, 32'hCA01FFFF, OKAY};

      // Reset state, and READYs held low until the first edge after release.
      repeat (3) @(negedge clk);
      check("rst_awready", 128'(awready), 128'(0));
      check("rst_bvalid", 128'(bvalid), 128'(0));
      check("rst_rvalid", 128'(rvalid), 128'(0));
      check("rst_rdata", 128'(rdata), 128'(0));
      check("rst_reg_out", reg_out, 128'(0));
      rst_n = 1'b1;
      #1;
      check("rel_awready_low", 128'(awready), 128'(0));
      check("rel_arready_low", 128'(arready), 128'(0));
      @(posedge clk); #1;
      check("rel_awready", 128'(awready), 128'(1));
      check("rel_wready", 128'(wready), 128'(1));
      check("rel_arready", 128'(arready), 128'(1));

      for (int i = 0; i < 8; i++) begin
         do_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].exp_resp);
         do_read(vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_resp);
         if (i == 3)
            check("reg_out_seq", reg_out, {32'hBEEF0011, 32'hDEAD0011, 32'hABCD0001, 32'h0101FFFF});
      end
      check("reg_out_table", reg_out, {32'hBEEF0011, 32'hDEAD0011, 32'hAB220044, 32'hCA01FFFF});

      // W leads AW by three cycles while BREADY is held low.
      bready = 1'b0;
      wdata = 32'h0F0F0F0F; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      check("skew_wready", 128'(wready), 128'(1));
      @(posedge clk); #1;
      wvalid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check("skew_wready_held", 128'(wready), 128'(0));
         check("skew_awready_open", 128'(awready), 128'(1));
         check("skew_bvalid_idle", 128'(bvalid), 128'(0));
         @(posedge clk); #1;
      end
      awaddr = 5'h0C; awvalid = 1'b1;
      @(negedge clk);
      check("skew_aw_hs", 128'(awready), 128'(1));
      @(posedge clk); #1;
      awvalid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("skew_bvalid", 128'(bvalid), 128'(1));
         check("skew_bresp", 128'(bresp), 128'(OKAY));
         check("skew_awready_stall", 128'(awready), 128'(0));
         check("skew_wready_stall", 128'(wready), 128'(0));
         @(posedge clk); #1;
      end
      b_q.push_back(OKAY);
      bready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("skew_bvalid_clear", 128'(bvalid), 128'(0));
      check("skew_awready_back", 128'(awready), 128'(1));
      @(posedge clk); #1;
      do_read(5'h0C, 32'h0F0F0F0F, OKAY);

      // Same-edge write commit and read of word 2, then RREADY stalled for 5 cycles.
      rready = 1'b0;
      awaddr = 5'h08; wdata = 32'h77777777; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 5'h08; arvalid = 1'b1;
      b_q.push_back(OKAY);
      r_q.push_back('{resp: OKAY, data: 32'hDEAD0011});
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("stall_rvalid", 128'(rvalid), 128'(1));
         check("stall_rdata", 128'(rdata), 128'(32'hDEAD0011));
         check("stall_arready", 128'(arready), 128'(0));
         @(posedge clk); #1;
      end
      rready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_rvalid_clear", 128'(rvalid), 128'(0));
      check("stall_arready_back", 128'(arready), 128'(1));
      @(posedge clk); #1;
      do_read(5'h08, 32'h77777777, OKAY);

      // Reset while both BVALID and RVALID are pending.
      bready = 1'b0; rready = 1'b0;
      awaddr = 5'h00; wdata = 32'h00000099; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 5'h04; arvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      @(negedge clk);
      check("pre_rst_bvalid", 128'(bvalid), 128'(1));
      check("pre_rst_rvalid", 128'(rvalid), 128'(1));
      check("pre_rst_word0", 128'(reg_out[31:0]), 128'(32'h00000099));
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_bvalid", 128'(bvalid), 128'(0));
      check("mid_rst_rvalid", 128'(rvalid), 128'(0));
      check("mid_rst_reg_out", reg_out, 128'(0));
      check("mid_rst_arready", 128'(arready), 128'(0));
      @(negedge clk);
      bready = 1'b1; rready = 1'b1;
      rst_n = 1'b1;
      #1;
      check("rel2_wready_low", 128'(wready), 128'(0));
      @(posedge clk); #1;
      check("rel2_wready", 128'(wready), 128'(1));
      for (int i = 0; i < 8; i++)
         do_read(5'(i * 4), 32'h0, (i >= 4) ? UNMAP : OKAY);

      check("b_queue_empty", 128'(b_q.size()), 128'(0));
      check("r_queue_empty", 128'(r_q.size()), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
